// File: rtl/omem_drain.sv
// Drains banks 0..DEPTH-1 of the output memory into a valid/ready stream.
// Reads flow through a 2-entry skid FIFO so the stream can stall without losing data.
module omem_drain #(
    parameter int DEPTH = 60,
    parameter int WIDTH = 9,
    parameter int AW    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_bank,
    output logic             mem_rd,
    input  logic [WIDTH-1:0] mem_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [AW-1:0] LAST_BANK = AW'(DEPTH - 1);

    state_t           state_reg, state_next;
    logic [AW-1:0]    bank_reg, bank_next;
    logic             done_reg, done_next;
    logic             inflight_reg;
    logic             inflight_last_reg;
    logic [1:0]       count_reg, count_next;
    logic             wr_ptr_reg, rd_ptr_reg;
    logic             push, pop, is_last_bank, head_last;
    logic [2:0]       occupancy;
    logic [WIDTH-1:0] head_word;

    // Two storage slots; the one written is selected by the write pointer.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [WIDTH-1:0] word_reg;
        logic             last_reg;
        always_ff @(posedge clock) begin
            if (push && wr_ptr_reg == 1'(gi)) begin
                word_reg <= mem_in;
                last_reg <= inflight_last_reg;
            end
        end
    end

    assign head_word    = rd_ptr_reg ? g_entry[1].word_reg : g_entry[0].word_reg;
    assign head_last    = rd_ptr_reg ? g_entry[1].last_reg : g_entry[0].last_reg;
    assign push         = inflight_reg;
    assign out_valid    = (count_reg != 2'd0);
    assign pop          = out_valid & out_ready;
    assign out_data     = out_valid ? head_word : '0;
    assign out_last     = out_valid & head_last;
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign mem_bank     = busy ? bank_reg : '0;
    assign is_last_bank = (bank_reg == LAST_BANK);
    assign occupancy    = {1'b0, count_reg} + {2'b00, inflight_reg};

    always_comb begin
        state_next = state_reg;
        bank_next  = bank_reg;
        done_next  = 1'b0;
        mem_rd     = 1'b0;
        count_next = count_reg + {1'b0, push} - {1'b0, pop};
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    bank_next  = '0;
                end
            end
            RUN: begin
                // Only issue when the word will have a free slot on arrival.
                if (occupancy < (3'd2 + {2'b00, pop})) begin
                    mem_rd = 1'b1;
                    if (is_last_bank) begin
                        state_next = FLUSH;
                    end else begin
                        bank_next = bank_reg + AW'(1);
                    end
                end
            end
            FLUSH: begin
                if (pop && head_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= IDLE;
            bank_reg          <= '0;
            done_reg          <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            count_reg         <= 2'd0;
            wr_ptr_reg        <= 1'b0;
            rd_ptr_reg        <= 1'b0;
        end else begin
            state_reg         <= state_next;
            bank_reg          <= bank_next;
            done_reg          <= done_next;
            inflight_reg      <= mem_rd;
            inflight_last_reg <= mem_rd & is_last_bank;
            count_reg         <= count_next;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

endmodule

// File: tb/tb_omem_drain.sv
// Bench for omem_drain: a DEPTH=4 vector table plus DEPTH=60 frames checked against
// a stream scoreboard built from the memory contents and the stated latencies.
module tb_omem_drain;

    localparam int D = 60;

    logic       clk = 1'b0;
    logic       reset, start, out_ready;
    logic       busy, done, mem_rd, out_valid, out_last;
    logic [5:0] mem_bank;
    logic [8:0] mem_in, out_data;

    logic       start4, ready4, busy4, done4, rd4, valid4, last4;
    logic [1:0] bank4;
    logic [8:0] in4, data4;

    logic [8:0] mem  [0:63];
    logic [8:0] mem4 [0:3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    omem_drain #(.DEPTH(60), .WIDTH(9), .AW(6)) dut (
        .clock(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_bank(mem_bank), .mem_rd(mem_rd), .mem_in(mem_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    omem_drain #(.DEPTH(4), .WIDTH(9), .AW(2)) dut4 (
        .clock(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
        .mem_bank(bank4), .mem_rd(rd4), .mem_in(in4), .out_data(data4),
        .out_valid(valid4), .out_ready(ready4), .out_last(last4)
    );

    // Memory behaviour: registered read, data held while rd is low.
    always @(posedge clk) begin
        if (mem_rd) mem_in <= mem[mem_bank];
        if (rd4)    in4    <= mem4[bank4];
    end

    typedef struct {
        bit         st;
        bit         rdy;
        bit         busy;
        bit         done;
        bit         valid;
        logic [8:0] data;
        bit         last;
        bit         rd;
        logic [1:0] bank;
        bit         chk_bank;
    } vec_t;

    vec_t tbl [9];

    // Sampled outputs and scoreboard state.
    logic       s_busy, s_done, s_rd, s_valid, s_last;
    logic [5:0] s_bank;
    logic [8:0] s_data;
    logic [9:0] exp_q [$];
    int fc, rd_next, issued, popped, max_occ, hs, last_hs_fc, done_cnt;
    bit prev_stall;
    logic [8:0] prev_data;
    logic prev_last;

    function automatic bit ready_for(input int mode, input int f);
        case (mode)
            0:       return 1'b1;
            1:       return (f % 2) == 0;
            2:       return $urandom_range(0, 3) != 0;
            3:       return !(f >= 8 && f < 18);
            default: return 1'b1;
        endcase
    endfunction

    // One clock cycle: drive, sample at negedge, score, advance to posedge+1.
    task automatic cycle(input bit st, input bit rdy, input bit rs);
        logic [9:0] item;
        start = st; out_ready = rdy; reset = rs;
        @(negedge clk);
        s_busy = busy; s_done = done; s_rd = mem_rd; s_valid = out_valid;
        s_last = out_last; s_bank = mem_bank; s_data = out_data;
        if (issued - popped > max_occ) max_occ = issued - popped;
        if (s_rd) begin
            checks++;
            if (!s_busy || s_bank != 6'(rd_next) || s_bank >= 6'(D))
                $display("FAIL rd_order: fc=%0d bank=%0d busy=%b, required bank %0d while busy",
                         fc, s_bank, s_busy, rd_next);
            if (!s_busy || s_bank != 6'(rd_next) || s_bank >= 6'(D)) errors++;
            rd_next++; issued++;
        end
        if (prev_stall) begin
            checks++;
            if (!s_valid || s_data != prev_data || s_last != prev_last) begin
                errors++;
                $display("FAIL hold: fc=%0d valid=%b data=%0d last=%b, required valid=1 data=%0d last=%b",
                         fc, s_valid, s_data, s_last, prev_data, prev_last);
            end
        end
        if (s_valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_word: fc=%0d data=%0d, required no further word", fc, s_data);
            end else begin
                item = exp_q.pop_front();
                if (s_data != item[8:0] || s_last != item[9]) begin
                    errors++;
                    $display("FAIL word: fc=%0d data=%0d last=%b, required data=%0d last=%b",
                             fc, s_data, s_last, item[8:0], item[9]);
                end
            end
            $display("hs fc=%0d data=%0d last=%b", fc, s_data, s_last);
            hs++; popped++; last_hs_fc = fc;
        end
        if (s_done) begin
            checks++;
            if (s_busy || fc != last_hs_fc + 1 || done_cnt != 0) begin
                errors++;
                $display("FAIL done_timing: fc=%0d busy=%b prior_dones=%0d, required fc=%0d busy=0 once",
                         fc, s_busy, done_cnt, last_hs_fc + 1);
            end
            done_cnt++;
        end
        prev_stall = s_valid && !rdy && !rs;
        prev_data  = s_data;
        prev_last  = s_last;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_frame(input int mode, input bit exact, input int extra_fc,
                             input bit chain, input bit skip, input int rst_fc);
        int budget;
        bit fin, st, rdy, rs, eb, ev, el, ed, er, ok;
        logic [8:0] edata;
        budget = 2000; fin = 0;
        exp_q.delete();
        for (int i = 0; i < D; i++) exp_q.push_back({(i == D - 1) ? 1'b1 : 1'b0, mem[i]});
        rd_next = 0; issued = 0; popped = 0; max_occ = 0; hs = 0;
        last_hs_fc = -10; done_cnt = 0; prev_stall = 0;
        fc = skip ? 1 : 0;
        while (!fin && budget > 0) begin
            st  = (fc == 0 && !skip) || fc == extra_fc || (chain && fc == D + 3);
            rs  = (fc == rst_fc);
            rdy = rs ? 1'b0 : ready_for(mode, fc);
            cycle(st, rdy, rs);
            if (exact) begin
                eb = fc >= 1 && fc <= D + 2;
                ev = fc >= 3 && fc <= D + 2;
                el = fc == D + 2;
                ed = fc == D + 3;
                er = fc >= 1 && fc <= D;
                edata = ev ? mem[fc - 3] : 9'd0;
                ok = s_busy == eb && s_valid == ev && s_last == el && s_done == ed &&
                     s_rd == er && (!ev || s_data == edata) &&
                     (!er || s_bank == 6'(fc - 1)) && (eb || s_bank == 6'd0);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL exact fc=%0d: busy=%b valid=%b data=%0d last=%b done=%b rd=%b bank=%0d, required busy=%b valid=%b data=%0d last=%b done=%b rd=%b",
                             fc, s_busy, s_valid, s_data, s_last, s_done, s_rd, s_bank,
                             eb, ev, edata, el, ed, er);
                end
            end
            if (mode == 3 && fc >= 8 && fc < 18) begin
                checks++;
                if (!s_valid || s_data != 9'd105 || (fc >= 10 && s_rd)) begin
                    errors++;
                    $display("FAIL stall fc=%0d: valid=%b data=%0d rd=%b, required valid=1 data=105 rd=%b",
                             fc, s_valid, s_data, s_rd, (fc < 10) ? 1'bx : 1'b0);
                end
            end
            if (rst_fc >= 0 && fc == rst_fc + 1) begin
                checks++;
                if (s_busy || s_done || s_rd || s_bank != 0 || s_valid || s_last || s_data != 0) begin
                    errors++;
                    $display("FAIL post_reset: busy=%b done=%b rd=%b bank=%0d valid=%b last=%b data=%0d, required all 0",
                             s_busy, s_done, s_rd, s_bank, s_valid, s_last, s_data);
                end
                fin = 1;
            end
            if (s_done) fin = 1;
            fc++; budget--;
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL timeout: frame mode %0d got %0d words, required done within budget", mode, hs);
        end else if (rst_fc < 0) begin
            checks++;
            if (exp_q.size() != 0 || hs != D || done_cnt != 1 || max_occ > 2) begin
                errors++;
                $display("FAIL frame_end mode %0d: words=%0d left=%0d dones=%0d max_occ=%0d, required %0d 0 1 <=2",
                         mode, hs, exp_q.size(), done_cnt, max_occ, D);
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                cycle(1'b0, 1'b1, 1'b0);
                checks++;
                if (s_done || s_busy) begin
                    errors++;
                    $display("FAIL after_reset: done=%b busy=%b, required 0 0", s_done, s_busy);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; start4 = 1'b0; ready4 = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 9'(i + 100);
        mem4[0] = 9'd7; mem4[1] = 9'd8; mem4[2] = 9'd9; mem4[3] = 9'd10;

        //            st rdy busy done valid data last rd bank chk
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0, 2'd0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 2'd0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 2'd1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd7,  1'b0, 1'b1, 2'd2, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd8,  1'b0, 1'b1, 2'd3, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd9,  1'b0, 1'b0, 2'd0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd10, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0,  1'b0, 1'b0, 2'd0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0, 2'd0, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy || done || mem_rd || mem_bank != 0 || out_valid || out_last || out_data != 0 ||
            busy4 || done4 || rd4 || bank4 != 0 || valid4 || last4 || data4 != 0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b rd=%b bank=%0d valid=%b last=%b data=%0d, required all 0",
                     busy, done, mem_rd, mem_bank, out_valid, out_last, out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // DEPTH=4 cycle table
        for (int i = 0; i < 9; i++) begin
            bit ok;
            start4 = tbl[i].st; ready4 = tbl[i].rdy;
            @(negedge clk);
            ok = busy4 == tbl[i].busy && done4 == tbl[i].done && valid4 == tbl[i].valid &&
                 (!tbl[i].valid || data4 == tbl[i].data) && last4 == tbl[i].last &&
                 rd4 == tbl[i].rd && (!tbl[i].chk_bank || bank4 == tbl[i].bank);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL d4_row%0d: busy=%b done=%b valid=%b data=%0d last=%b rd=%b bank=%0d, required %b %b %b %0d %b %b %0d",
                         i, busy4, done4, valid4, data4, last4, rd4, bank4, tbl[i].busy, tbl[i].done,
                         tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].rd, tbl[i].bank);
            end else begin
                $display("d4 row %0d: valid=%b data=%0d last=%b done=%b", i, valid4, data4, last4, done4);
            end
            @(posedge clk); #1;
        end
        start4 = 1'b0;

        run_frame(0, 1'b1, -1, 1'b0, 1'b0, -1);    // full-rate drain
        idle(2);
        run_frame(1, 1'b0, -1, 1'b0, 1'b0, -1);    // alternating ready
        idle(2);
        run_frame(3, 1'b0, -1, 1'b0, 1'b0, -1);    // 10-cycle stall on word 105
        idle(2);
        run_frame(0, 1'b1, 20, 1'b1, 1'b0, -1);    // stray start, then restart on done
        run_frame(0, 1'b1, -1, 1'b0, 1'b1, -1);
        idle(2);
        run_frame(0, 1'b0, -1, 1'b0, 1'b0, 34);    // reset after word 30
        run_frame(0, 1'b1, -1, 1'b0, 1'b0, -1);
        idle(2);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < D; i++) mem[i] = 9'($urandom_range(0, 511));
            run_frame(2, 1'b0, -1, 1'b0, 1'b0, -1);
            idle(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
